pds_e_sequencer: RTL and testbench

//  6800-style synchronous bus sequencer for the SE PDS side of the accelerator, clocked on cpuClock.
//  - Recovers C8M phase and generates the E clock.
//  - On VPA cycles, sequences VMA and produces the E-synchronous termination/autovector request.
//  - The bus-translation stage converts that request to DSACK0 (memory/I-O) or AVEC (FC=7).

---
 rtl/pds_pkg.sv | 20 ++
 rtl/pds_sync.sv | 24 ++
 rtl/pds_e_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_pds_e_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pds_pkg.sv
// Shared types for the SE PDS 6800-style bus sequencer: FSM state encoding,
// the CPU-space function code and the E-phase step helper.
package pds_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_VMA = 3'd1,
    VMA_ACT  = 3'd2,
    TERM     = 3'd3,
    DONE     = 3'd4
  } e_seq_state_t;

  localparam logic [2:0] FC_CPU_SPACE = 3'h7;

  // E phase advance: wraps to 0 after the last phase of the period.
  function automatic logic [3:0] phase_next(input logic [3:0] cur, input logic [3:0] last);
    return (cur == last) ? 4'd0 : cur + 4'd1;
  endfunction

endpackage

// File: rtl/pds_sync.sv
// Flop-chain synchronizer for asynchronous PDS inputs entering the cpuClock domain.
// All stages clear to 0 on reset.
module pds_sync #(
  parameter int STAGES = 2
) (
  input  logic cpuClock,
  input  logic pdsRESETn,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge cpuClock or negedge pdsRESETn) begin
    if (!pdsRESETn) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/pds_e_sequencer.sv
// 6800-style synchronous bus sequencer: recovers C8M, generates E, sequences VMA and
// requests DSACK/AVEC termination. Optional AS watchdog enabled by PDS_TIMEOUT_EN.
module pds_e_sequencer
  import pds_pkg::*;
#(
  parameter int E_DIV        = 10,
  parameter int E_HIGH_START = 6,
  parameter int VMA_PHASE    = 2,
  parameter int TERM_PHASE   = 9,
  parameter int SYNC_STAGES  = 2
`ifdef PDS_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic       cpuClock,
  input  logic       pdsRESETn,
  input  logic       pdsC8M,
  input  logic       cpuASn,
  input  logic [2:0] cpuFC,
  input  logic       pdsVPAn,
  output logic       pdsClockE,
  output logic       pdsVMAn,
  output logic       term68n,
  output logic       avec68n,
  output logic [3:0] eCount,
  output logic       timeoutBERRn,
  output logic [2:0] o_dbg_state
);

  localparam logic [3:0] LP_LAST   = 4'(E_DIV - 1);
  localparam logic [3:0] LP_E_HIGH = 4'(E_HIGH_START);
  localparam logic [3:0] LP_VMA    = 4'(VMA_PHASE);
  localparam logic [3:0] LP_TERM   = 4'(TERM_PHASE);

  logic         w_c8m_s;
  logic         w_vpa_n_s;
  logic         r_c8m_prev;
  logic         w_c8m_rise;
  logic [3:0]   r_ecount;
  logic [3:0]   w_ecount_next;
  logic         r_clock_e;
  logic         w_cycle_active;
  logic         w_hit_vma;
  logic         w_hit_term;
  logic         w_hit_wrap;
  e_seq_state_t r_state;
  e_seq_state_t w_state_next;
  logic         r_cpu_space;
  logic         w_cpu_space_next;
  logic         r_vma_n;
  logic         r_term_n;
  logic         r_avec_n;
  logic         w_vma_n_next;
  logic         w_term_n_next;
  logic         w_avec_n_next;

  pds_sync #(.STAGES(SYNC_STAGES)) u_sync_c8m (
    .cpuClock  (cpuClock),
    .pdsRESETn (pdsRESETn),
    .i_d       (pdsC8M),
    .o_q       (w_c8m_s)
  );

  pds_sync #(.STAGES(2)) u_sync_vpa (
    .cpuClock  (cpuClock),
    .pdsRESETn (pdsRESETn),
    .i_d       (pdsVPAn),
    .o_q       (w_vpa_n_s)
  );

  // ---------------- C8M recovery, free-running E phase counter ----------------
  assign w_c8m_rise    = w_c8m_s & ~r_c8m_prev;
  assign w_ecount_next = w_c8m_rise ? phase_next(r_ecount, LP_LAST) : r_ecount;

  always_ff @(posedge cpuClock or negedge pdsRESETn) begin
    if (!pdsRESETn) begin
      r_c8m_prev <= 1'b0;
      r_ecount   <= 4'd0;
      r_clock_e  <= 1'b0;
    end else begin
      r_c8m_prev <= w_c8m_s;
      r_ecount   <= w_ecount_next;
      r_clock_e  <= (r_ecount >= LP_E_HIGH);
    end
  end

  // Phase events are qualified by the rise so a phase is hit exactly once per period.
  assign w_cycle_active = ~cpuASn & ~w_vpa_n_s;
  assign w_hit_vma      = w_c8m_rise && (w_ecount_next == LP_VMA);
  assign w_hit_term     = w_c8m_rise && (w_ecount_next == LP_TERM);
  assign w_hit_wrap     = w_c8m_rise && (w_ecount_next == 4'd0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge cpuClock or negedge pdsRESETn) begin
    if (!pdsRESETn) begin
      r_state     <= IDLE;
      r_cpu_space <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cpu_space <= w_cpu_space_next;
    end
  end

  // ---------------- FSM: next state ----------------
  // AS negation wins over every phase event; vpa only matters before VMA is driven.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_cycle_active) w_state_next = WAIT_VMA;
      end
      WAIT_VMA: begin
        if (cpuASn || w_vpa_n_s) w_state_next = IDLE;
        else if (w_hit_vma)      w_state_next = VMA_ACT;
      end
      VMA_ACT: begin
        if (cpuASn)          w_state_next = IDLE;
        else if (w_hit_term) w_state_next = TERM;
      end
      TERM: begin
        if (cpuASn)          w_state_next = IDLE;
        else if (w_hit_wrap) w_state_next = DONE;
      end
      DONE: begin
        if (cpuASn) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs (registered from next state) ----------------
  // FC is captured on entry to TERM so term and avec can never both assert.
  always_comb begin
    w_cpu_space_next = r_cpu_space;
    if ((w_state_next == TERM) && (r_state != TERM)) begin
      w_cpu_space_next = (cpuFC == FC_CPU_SPACE);
    end
    w_vma_n_next  = ~((w_state_next == VMA_ACT) || (w_state_next == TERM));
    w_term_n_next = 1'b1;
    w_avec_n_next = 1'b1;
    if ((w_state_next == TERM) || (w_state_next == DONE)) begin
      w_term_n_next = w_cpu_space_next;
      w_avec_n_next = ~w_cpu_space_next;
    end
  end

  always_ff @(posedge cpuClock or negedge pdsRESETn) begin
    if (!pdsRESETn) begin
      r_vma_n  <= 1'b1;
      r_term_n <= 1'b1;
      r_avec_n <= 1'b1;
    end else begin
      r_vma_n  <= w_vma_n_next;
      r_term_n <= w_term_n_next;
      r_avec_n <= w_avec_n_next;
    end
  end

  // ---------------- Optional AS watchdog ----------------
`ifdef PDS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] LP_WD_MAX = WD_W'(TIMEOUT_CYC);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_berr_n;
  logic            w_wd_reaching;

  // Fires on the clock edge at which the count lands on the limit.
  assign w_wd_reaching = (r_wd_cnt >= (LP_WD_MAX - 1'b1));

  always_ff @(posedge cpuClock or negedge pdsRESETn) begin
    if (!pdsRESETn) begin
      r_wd_cnt <= '0;
      r_berr_n <= 1'b1;
    end else if (cpuASn) begin
      r_wd_cnt <= '0;
      r_berr_n <= 1'b1;
    end else begin
      if (r_wd_cnt != LP_WD_MAX) r_wd_cnt <= r_wd_cnt + 1'b1;
      if (w_wd_reaching && (r_state != TERM) && (r_state != DONE)) r_berr_n <= 1'b0;
    end
  end

  assign timeoutBERRn = r_berr_n;
`else
  assign timeoutBERRn = 1'b1;
`endif

  assign pdsClockE   = r_clock_e;
  assign pdsVMAn     = r_vma_n;
  assign term68n     = r_term_n;
  assign avec68n     = r_avec_n;
  assign eCount      = r_ecount;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pds_e_sequencer.sv
// Directed bench for pds_e_sequencer: E generation, VPA cycles, AVEC, abort, reset
// and the AS watchdog (PDS_TIMEOUT_EN selects which watchdog behaviour is expected).
`timescale 1ns/1ps
module tb_pds_e_sequencer;
  import pds_pkg::*;

  logic       cpuClock = 1'b0;
  logic       pdsRESETn = 1'b0;
  logic       pdsC8M = 1'b0;
  logic       cpuASn = 1'b1;
  logic [2:0] cpuFC = 3'd0;
  logic       pdsVPAn = 1'b1;
  logic       pdsClockE;
  logic       pdsVMAn;
  logic       term68n;
  logic       avec68n;
  logic [3:0] eCount;
  logic       timeoutBERRn;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  pds_e_sequencer dut (
    .cpuClock     (cpuClock),
    .pdsRESETn    (pdsRESETn),
    .pdsC8M       (pdsC8M),
    .cpuASn       (cpuASn),
    .cpuFC        (cpuFC),
    .pdsVPAn      (pdsVPAn),
    .pdsClockE    (pdsClockE),
    .pdsVMAn      (pdsVMAn),
    .term68n      (term68n),
    .avec68n      (avec68n),
    .eCount       (eCount),
    .timeoutBERRn (timeoutBERRn),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock/reset ----------------
  always #20 cpuClock = ~cpuClock;
  initial begin
    #7;
    forever #63.825 pdsC8M = ~pdsC8M;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances to the first falling cpuClock edge of a fresh eCount==v phase.
  task automatic wait_ec(input logic [3:0] v);
    int n;
    n = 0;
    while (eCount == v && n < 100) begin @(negedge cpuClock); n++; end
    while (eCount != v && n < 200) begin @(negedge cpuClock); n++; end
    chk("wait_ecount", {28'd0, eCount}, {28'd0, v});
  endtask

  task automatic end_cycle();
    cpuASn  = 1'b1;
    pdsVPAn = 1'b1;
    @(negedge cpuClock);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0] prev;
    int k;

    // Reset values
    repeat (3) @(negedge cpuClock);
    chk("rst_ecount", {28'd0, eCount}, 32'd0);
    chk("rst_clke", {31'd0, pdsClockE}, 32'd0);
    chk("rst_vma", {31'd0, pdsVMAn}, 32'd1);
    chk("rst_term", {31'd0, term68n}, 32'd1);
    chk("rst_avec", {31'd0, avec68n}, 32'd1);
    chk("rst_berr", {31'd0, timeoutBERRn}, 32'd1);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, IDLE});
    pdsRESETn = 1'b1;

    // 1: free-running E with no VPA
    wait_ec(4'd0);
    prev = 4'd0;
    for (int i = 0; i < 70; i++) begin
      @(negedge cpuClock);
      if (eCount != prev) begin
        chk("ecount_step", {28'd0, eCount}, (prev == 4'd9) ? 32'd0 : {28'd0, prev} + 32'd1);
      end else begin
        chk("clock_e", {31'd0, pdsClockE}, (eCount >= 4'd6) ? 32'd1 : 32'd0);
      end
      prev = eCount;
    end
    chk("idle_vma", {31'd0, pdsVMAn}, 32'd1);
    chk("idle_term", {31'd0, term68n}, 32'd1);
    chk("idle_avec", {31'd0, avec68n}, 32'd1);

    // 2: VPA cycle, FC=5, started at eCount=0
    wait_ec(4'd0);
    cpuFC = 3'd5; cpuASn = 1'b0; pdsVPAn = 1'b0;
    wait_ec(4'd1);
    chk("t2_state_wait", {29'd0, dbg_state}, {29'd0, WAIT_VMA});
    chk("t2_vma_pre", {31'd0, pdsVMAn}, 32'd1);
    wait_ec(4'd2);
    chk("t2_vma_on", {31'd0, pdsVMAn}, 32'd0);
    chk("t2_term_pre", {31'd0, term68n}, 32'd1);
    wait_ec(4'd9);
    chk("t2_term_on", {31'd0, term68n}, 32'd0);
    chk("t2_avec_off", {31'd0, avec68n}, 32'd1);
    chk("t2_vma_term", {31'd0, pdsVMAn}, 32'd0);
    wait_ec(4'd0);
    chk("t2_vma_off", {31'd0, pdsVMAn}, 32'd1);
    chk("t2_term_held", {31'd0, term68n}, 32'd0);
    chk("t2_state_done", {29'd0, dbg_state}, {29'd0, DONE});
    end_cycle();
    chk("t2_term_neg", {31'd0, term68n}, 32'd1);
    chk("t2_state_idle", {29'd0, dbg_state}, {29'd0, IDLE});

    // 3: VPA arrives at eCount=4 and waits for the next period
    wait_ec(4'd4);
    cpuFC = 3'd1; cpuASn = 1'b0; pdsVPAn = 1'b0;
    wait_ec(4'd9);
    chk("t3_vma_wait", {31'd0, pdsVMAn}, 32'd1);
    chk("t3_term_wait", {31'd0, term68n}, 32'd1);
    chk("t3_state_wait", {29'd0, dbg_state}, {29'd0, WAIT_VMA});
    wait_ec(4'd2);
    chk("t3_vma_on", {31'd0, pdsVMAn}, 32'd0);
    wait_ec(4'd9);
    chk("t3_term_on", {31'd0, term68n}, 32'd0);
    wait_ec(4'd0);
    chk("t3_vma_off", {31'd0, pdsVMAn}, 32'd1);
    end_cycle();
    chk("t3_term_neg", {31'd0, term68n}, 32'd1);

    // 4: interrupt acknowledge (FC=7) requests AVEC instead of DSACK
    wait_ec(4'd0);
    cpuFC = 3'd7; cpuASn = 1'b0; pdsVPAn = 1'b0;
    wait_ec(4'd2);
    chk("t4_vma_on", {31'd0, pdsVMAn}, 32'd0);
    wait_ec(4'd9);
    chk("t4_avec_on", {31'd0, avec68n}, 32'd0);
    chk("t4_term_off", {31'd0, term68n}, 32'd1);
    wait_ec(4'd0);
    chk("t4_avec_held", {31'd0, avec68n}, 32'd0);
    chk("t4_term_off2", {31'd0, term68n}, 32'd1);
    end_cycle();
    chk("t4_avec_neg", {31'd0, avec68n}, 32'd1);

    // 5: AS negated in VMA_ACT at eCount=5
    wait_ec(4'd0);
    cpuFC = 3'd5; cpuASn = 1'b0; pdsVPAn = 1'b0;
    wait_ec(4'd5);
    chk("t5_state_vma", {29'd0, dbg_state}, {29'd0, VMA_ACT});
    chk("t5_vma_on", {31'd0, pdsVMAn}, 32'd0);
    end_cycle();
    chk("t5_vma_abort", {31'd0, pdsVMAn}, 32'd1);
    chk("t5_state_idle", {29'd0, dbg_state}, {29'd0, IDLE});
    wait_ec(4'd9);
    chk("t5_no_term", {31'd0, term68n}, 32'd1);
    chk("t5_no_avec", {31'd0, avec68n}, 32'd1);
    wait_ec(4'd0);
    chk("t5_no_term2", {31'd0, term68n}, 32'd1);

    // 5b: asynchronous reset mid-cycle
    cpuFC = 3'd5; cpuASn = 1'b0; pdsVPAn = 1'b0;
    wait_ec(4'd5);
    chk("t5b_vma_on", {31'd0, pdsVMAn}, 32'd0);
    #5 pdsRESETn = 1'b0;
    #1;
    chk("t5b_ecount", {28'd0, eCount}, 32'd0);
    chk("t5b_vma", {31'd0, pdsVMAn}, 32'd1);
    chk("t5b_state", {29'd0, dbg_state}, {29'd0, IDLE});
    chk("t5b_clke", {31'd0, pdsClockE}, 32'd0);
    cpuASn = 1'b1; pdsVPAn = 1'b1;
    repeat (2) @(negedge cpuClock);
    pdsRESETn = 1'b1;
    repeat (2) @(negedge cpuClock);

    // 6: AS held low with no VPA -- watchdog
    cpuFC = 3'd5; cpuASn = 1'b0;
    k = 0;
    while (timeoutBERRn === 1'b1 && k < 4200) begin @(negedge cpuClock); k++; end
`ifdef PDS_TIMEOUT_EN
    chk("t6_berr_clock", k, 32'd4096);
    repeat (5) @(negedge cpuClock);
    chk("t6_berr_held", {31'd0, timeoutBERRn}, 32'd0);
    end_cycle();
    chk("t6_berr_release", {31'd0, timeoutBERRn}, 32'd1);
`else
    chk("t6_berr_never", k, 32'd4200);
    chk("t6_berr_tied", {31'd0, timeoutBERRn}, 32'd1);
    end_cycle();
`endif
    chk("t6_state_idle", {29'd0, dbg_state}, {29'd0, IDLE});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
